main_counter: RTL and testbench

- Upstream neighbour of the timer/PWM compare stage.
- Generates the shared 16-bit main counter from chosen_clk through a programmable prescaler.
- Supports continuous (wrap) and one-shot (stop at period) modes, a software counter reset, and wrap/done status for the control register.
- Its counter output feeds the timer compare logic directly.

---
 rtl/pwm_timer_pkg.sv | 19 +
 rtl/clk_prescaler.sv | 50 +++++
 rtl/main_counter.sv | 131 +++++++++++++
 tb/tb_main_counter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the timer/PWM counter path.
//   CNT_W_DEF  default width of counter, divisor and period
//   state_e    main counter sequencing states
//   EN/CONT/CNT_RST  bit positions of the related fields in the control register
package pwm_timer_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int EN      = 2;
  localparam int CONT    = 3;
  localparam int CNT_RST = 7;

endpackage

// File: rtl/clk_prescaler.sv
// Programmable prescaler for the main counter.
//   clk           counter clock
//   rst_n         asynchronous active-low reset
//   run           count enable for this cycle
//   clr           synchronous clear of the divide count and tick
//   divisor_sync  registered divide value, 0 behaves as 1
//   strobe        terminal-count strobe for this cycle (drives the counter update)
//   tick          registered copy of strobe, high in the cycle the counter shows its new value
module clk_prescaler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [CNT_W-1:0] divisor_sync,
  output logic             strobe,
  output logic             tick
);

  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] div_cnt_d, div_cnt_q;
  logic             tick_d, tick_q;

  always_comb begin
    div_eff = (divisor_sync == '0) ? CNT_W'(1) : divisor_sync;
    // >= rather than == so a divisor shrunk below the running count terminates at once
    strobe  = run && !clr && (div_cnt_q >= (div_eff - CNT_W'(1)));
    div_cnt_d = div_cnt_q;
    if (clr || strobe) begin
      div_cnt_d = '0;
    end else if (run) begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
    tick_d = strobe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/main_counter.sv
// Shared main counter feeding the timer compare stage.
//   chosen_clk  counter clock
//   rst         asynchronous active-low reset
//   counter_en  counting enable
//   cont        1 = continuous (wrap), 0 = one-shot (stop at period)
//   cnt_rst     level-sensitive synchronous clear request
//   divisor     prescaler divide value
//   period_reg  terminal count
//   counter     main counter value
//   tick        one-cycle prescaler strobe
//   wrap        one-cycle pulse when the counter returns to 0
//   done        sticky one-shot completion flag
//
// state | meaning
// IDLE  | paused, counter and prescaler hold
// RUN   | prescaler running, counter advances on each tick
// DONE  | one-shot finished, counter frozen
module main_counter
  import pwm_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             chosen_clk,
  input  logic             rst,
  input  logic             counter_en,
  input  logic             cont,
  input  logic             cnt_rst,
  input  logic [CNT_W-1:0] divisor,
  input  logic [CNT_W-1:0] period_reg,
  output logic [CNT_W-1:0] counter,
  output logic             tick,
  output logic             wrap,
  output logic             done
);

  logic             en_sync_d, en_sync_q;
  logic             cont_sync_d, cont_sync_q;
  logic             cnt_rst_sync_d, cnt_rst_sync_q;
  logic [CNT_W-1:0] divisor_sync_d, divisor_sync_q;
  logic [CNT_W-1:0] period_sync_d, period_sync_q;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] counter_d, counter_q;
  logic             wrap_d, wrap_q;
  logic             done_d, done_q;
  logic             run;
  logic             strobe;

  // Counting starts in the same cycle IDLE sees the enable, so the first
  // increment lands one cycle after the enable is registered.
  assign run = en_sync_q && !cnt_rst_sync_q && ((state_q == IDLE) || (state_q == RUN));

  clk_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk          (chosen_clk),
    .rst_n        (rst),
    .run          (run),
    .clr          (cnt_rst_sync_q),
    .divisor_sync (divisor_sync_q),
    .strobe       (strobe),
    .tick         (tick)
  );

  always_comb begin
    en_sync_d      = counter_en;
    cont_sync_d    = cont;
    cnt_rst_sync_d = cnt_rst;
    divisor_sync_d = divisor;
    period_sync_d  = period_reg;

    state_d   = state_q;
    counter_d = counter_q;
    wrap_d    = 1'b0;
    done_d    = done_q;

    if (cnt_rst_sync_q) begin
      counter_d = '0;
      done_d    = 1'b0;
      state_d   = en_sync_q ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en_sync_q) state_d = RUN;
        RUN:     if (!en_sync_q) state_d = IDLE;
        DONE: begin
          if (!en_sync_q)      state_d = IDLE;
          else if (cont_sync_q) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase

      if (strobe) begin
        if (counter_q < period_sync_q) begin
          counter_d = counter_q + CNT_W'(1);
        end else if (cont_sync_q) begin
          counter_d = '0;
          wrap_d    = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge chosen_clk or negedge rst) begin
    if (!rst) begin
      en_sync_q      <= 1'b0;
      cont_sync_q    <= 1'b0;
      cnt_rst_sync_q <= 1'b0;
      divisor_sync_q <= '0;
      period_sync_q  <= '0;
      state_q        <= IDLE;
      counter_q      <= '0;
      wrap_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      en_sync_q      <= en_sync_d;
      cont_sync_q    <= cont_sync_d;
      cnt_rst_sync_q <= cnt_rst_sync_d;
      divisor_sync_q <= divisor_sync_d;
      period_sync_q  <= period_sync_d;
      state_q        <= state_d;
      counter_q      <= counter_d;
      wrap_q         <= wrap_d;
      done_q         <= done_d;
    end
  end

  assign counter = counter_q;
  assign wrap    = wrap_q;
  assign done    = done_q;

endmodule

// File: tb/tb_main_counter.sv
module tb_main_counter;

  typedef struct packed {
    logic [15:0] cnt;
    logic        tick;
    logic        wrap;
    logic        done;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        counter_en;
  logic        cont;
  logic        cnt_rst;
  logic [15:0] divisor;
  logic [15:0] period_reg;
  logic [15:0] counter;
  logic        tick;
  logic        wrap;
  logic        done;

  int checks = 0;
  int passed = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  main_counter #(.CNT_W(16)) dut (
    .chosen_clk (clk),
    .rst        (rst),
    .counter_en (counter_en),
    .cont       (cont),
    .cnt_rst    (cnt_rst),
    .divisor    (divisor),
    .period_reg (period_reg),
    .counter    (counter),
    .tick       (tick),
    .wrap       (wrap),
    .done       (done)
  );

  function automatic obs_t mk(int c, bit t, bit w, bit d);
    obs_t r;
    r.cnt  = 16'(c);
    r.tick = t;
    r.wrap = w;
    r.done = d;
    return r;
  endfunction

  // Closed-form expectation k edges after reset release, inputs steady from reset.
  // n = number of prescaler ticks so far (first possible tick on edge 2).
  function automatic obs_t model(int k, int d, int p, bit c);
    obs_t r;
    int   n;
    bit   t;
    n = (k >= 2) ? (k - 1) / d : 0;
    t = (k >= 2) && ((k - 1) % d == 0);
    r = '0;
    if (c) begin
      r.cnt  = 16'(n % (p + 1));
      r.tick = t;
      r.wrap = t && (n % (p + 1) == 0);
    end else begin
      r.cnt  = 16'((n < p) ? n : p);
      r.done = (n >= p + 1);
      r.tick = t && (n <= p + 1);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] d, input logic [15:0] p, input logic c, input logic e);
    rst        = 1'b0;
    divisor    = d;
    period_reg = p;
    cont       = c;
    counter_en = e;
    cnt_rst    = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, a;
    int   n;
    start(16'd1, 16'd20, 1'b1, 1'b1);
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front();
    a = {counter, tick, wrap, done};
    checks++;
    if (a !== e) $display("FAIL reset_release got %h want %h", a, e);
    else passed++;
    for (int k = 1; k <= 6; k++) exp_q.push_back(model(k, 1, 20, 1'b1));
    n = exp_q.size();
    for (int k = 1; k <= n; k++) begin
      step();
      e = exp_q.pop_front();
      a = {counter, tick, wrap, done};
      checks++;
      if (a !== e) $display("FAIL reset_precount k=%0d got cnt=%0d t=%0b w=%0b d=%0b want cnt=%0d t=%0b w=%0b d=%0b",
                            k, a.cnt, a.tick, a.wrap, a.done, e.cnt, e.tick, e.wrap, e.done);
      else passed++;
    end
    #3;
    rst = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    a = {counter, tick, wrap, done};
    checks++;
    if (a !== e) $display("FAIL reset_async got %h want %h", a, e);
    else passed++;
    step();
    e = exp_q.pop_front();
    a = {counter, tick, wrap, done};
    checks++;
    if (a !== e) $display("FAIL reset_held got %h want %h", a, e);
    else passed++;
  endtask

  task automatic test_continuous();
    obs_t e, a;
    int   n, p;
    for (int cfg = 0; cfg < 2; cfg++) begin
      p = (cfg == 0) ? 3 : 0;
      start(16'd1, 16'(p), 1'b1, 1'b1);
      for (int k = 1; k <= 14; k++) exp_q.push_back(model(k, 1, p, 1'b1));
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
        step();
        e = exp_q.pop_front();
        a = {counter, tick, wrap, done};
        checks++;
        if (a !== e) $display("FAIL continuous p=%0d k=%0d got cnt=%0d t=%0b w=%0b d=%0b want cnt=%0d t=%0b w=%0b d=%0b",
                              p, k, a.cnt, a.tick, a.wrap, a.done, e.cnt, e.tick, e.wrap, e.done);
        else passed++;
      end
    end
  endtask

  task automatic test_prescaler();
    obs_t e, a;
    int   n, d, deff, p, len;
    for (int cfg = 0; cfg < 2; cfg++) begin
      d    = (cfg == 0) ? 4 : 0;
      deff = (cfg == 0) ? 4 : 1;
      p    = (cfg == 0) ? 2 : 3;
      len  = (cfg == 0) ? 30 : 12;
      start(16'(d), 16'(p), 1'b1, 1'b1);
      for (int k = 1; k <= len; k++) exp_q.push_back(model(k, deff, p, 1'b1));
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
        step();
        e = exp_q.pop_front();
        a = {counter, tick, wrap, done};
        checks++;
        if (a !== e) $display("FAIL prescaler div=%0d k=%0d got cnt=%0d t=%0b w=%0b d=%0b want cnt=%0d t=%0b w=%0b d=%0b",
                              d, k, a.cnt, a.tick, a.wrap, a.done, e.cnt, e.tick, e.wrap, e.done);
        else passed++;
      end
    end
  endtask

  task automatic test_one_shot();
    obs_t e, a;
    int   n;
    start(16'd2, 16'd5, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) exp_q.push_back(model(k, 2, 5, 1'b0));
    exp_q.push_back(mk(5, 0, 0, 1));
    for (int k = 22; k <= 36; k++) exp_q.push_back(model(k - 21, 2, 5, 1'b0));
    n = exp_q.size();
    for (int k = 1; k <= n; k++) begin
      step();
      e = exp_q.pop_front();
      a = {counter, tick, wrap, done};
      checks++;
      if (a !== e) $display("FAIL one_shot k=%0d got cnt=%0d t=%0b w=%0b d=%0b want cnt=%0d t=%0b w=%0b d=%0b",
                            k, a.cnt, a.tick, a.wrap, a.done, e.cnt, e.tick, e.wrap, e.done);
      else passed++;
      if (k == 20) cnt_rst = 1'b1;
      if (k == 21) cnt_rst = 1'b0;
    end
    start(16'd1, 16'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) exp_q.push_back(model(k, 1, 0, 1'b0));
    n = exp_q.size();
    for (int k = 1; k <= n; k++) begin
      step();
      e = exp_q.pop_front();
      a = {counter, tick, wrap, done};
      checks++;
      if (a !== e) $display("FAIL one_shot_p0 k=%0d got cnt=%0d t=%0b w=%0b d=%0b want cnt=%0d t=%0b w=%0b d=%0b",
                            k, a.cnt, a.tick, a.wrap, a.done, e.cnt, e.tick, e.wrap, e.done);
      else passed++;
    end
  endtask

  task automatic test_pause();
    obs_t e, a;
    int   n;
    start(16'd1, 16'd20, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) exp_q.push_back(model(k, 1, 20, 1'b1));
    for (int k = 9; k <= 13; k++) exp_q.push_back(mk(7, 0, 0, 0));
    exp_q.push_back(mk(8, 1, 0, 0));
    exp_q.push_back(mk(9, 1, 0, 0));
    n = exp_q.size();
    for (int k = 1; k <= n; k++) begin
      step();
      e = exp_q.pop_front();
      a = {counter, tick, wrap, done};
      checks++;
      if (a !== e) $display("FAIL pause k=%0d got cnt=%0d t=%0b w=%0b d=%0b want cnt=%0d t=%0b w=%0b d=%0b",
                            k, a.cnt, a.tick, a.wrap, a.done, e.cnt, e.tick, e.wrap, e.done);
      else passed++;
      if (k == 7)  counter_en = 1'b0;
      if (k == 12) counter_en = 1'b1;
    end
  endtask

  task automatic test_period_change();
    obs_t e, a;
    int   n;
    bit   c;
    for (int cfg = 0; cfg < 2; cfg++) begin
      c = (cfg == 0);
      start(16'd1, 16'd20, c, 1'b1);
      for (int k = 1; k <= 8; k++) exp_q.push_back(model(k, 1, 20, c));
      if (c) begin
        exp_q.push_back(mk(0, 1, 1, 0));
        for (int k = 10; k <= 13; k++) exp_q.push_back(mk(k - 9, 1, 0, 0));
        exp_q.push_back(mk(0, 1, 1, 0));
      end else begin
        exp_q.push_back(mk(7, 1, 0, 1));
        for (int k = 10; k <= 13; k++) exp_q.push_back(mk(7, 0, 0, 1));
        exp_q.push_back(mk(0, 1, 1, 1));
        exp_q.push_back(mk(1, 1, 0, 1));
      end
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
        step();
        e = exp_q.pop_front();
        a = {counter, tick, wrap, done};
        checks++;
        if (a !== e) $display("FAIL period_change cont=%0b k=%0d got cnt=%0d t=%0b w=%0b d=%0b want cnt=%0d t=%0b w=%0b d=%0b",
                              c, k, a.cnt, a.tick, a.wrap, a.done, e.cnt, e.tick, e.wrap, e.done);
        else passed++;
        if (k == 7) period_reg = 16'd4;
        if (k == 11) cont = 1'b1;
      end
    end
  endtask

  task automatic test_priority();
    obs_t e, a;
    int   n;
    bit   c;
    for (int cfg = 0; cfg < 2; cfg++) begin
      c = (cfg == 0);
      start(16'd1, 16'd3, c, 1'b1);
      for (int k = 1; k <= 4; k++) exp_q.push_back(model(k, 1, 3, c));
      exp_q.push_back(mk(0, 0, 0, 0));
      exp_q.push_back(mk(1, 1, 0, 0));
      exp_q.push_back(mk(2, 1, 0, 0));
      exp_q.push_back(mk(3, 1, 0, 0));
      for (int k = 9; k <= 12; k++) exp_q.push_back(mk(0, 0, 0, 0));
      exp_q.push_back(mk(1, 1, 0, 0));
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
        step();
        e = exp_q.pop_front();
        a = {counter, tick, wrap, done};
        checks++;
        if (a !== e) $display("FAIL priority cont=%0b k=%0d got cnt=%0d t=%0b w=%0b d=%0b want cnt=%0d t=%0b w=%0b d=%0b",
                              c, k, a.cnt, a.tick, a.wrap, a.done, e.cnt, e.tick, e.wrap, e.done);
        else passed++;
        if (k == 3)  cnt_rst = 1'b1;
        if (k == 4)  cnt_rst = 1'b0;
        if (k == 7)  cnt_rst = 1'b1;
        if (k == 11) cnt_rst = 1'b0;
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    counter_en = 1'b0;
    cont       = 1'b0;
    cnt_rst    = 1'b0;
    divisor    = 16'd0;
    period_reg = 16'd0;
    test_reset();
    test_continuous();
    test_prescaler();
    test_one_shot();
    test_pause();
    test_period_change();
    test_priority();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
